// File: rtl/add_pkg.sv
// Shared types for the serial adder.
// Holds the FSM state encoding used by add_serial.
package add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/add_chunk.sv
// Combinational K-bit adder slice with carry in/out.
// Ports: i_a, i_b (K) + i_cin -> o_sum (K), o_cout.
module add_chunk #(
  parameter int K = 2
) (
  input  logic [K-1:0] i_a,
  input  logic [K-1:0] i_b,
  input  logic         i_cin,
  output logic [K-1:0] o_sum,
  output logic         o_cout
);

  logic [K:0] w_full;

  assign w_full = {1'b0, i_a}
                + {1'b0, i_b}
                + {{K{1'b0}}, i_cin};
  assign o_sum  = w_full[K-1:0];
  assign o_cout = w_full[K];

endmodule

// File: rtl/add_serial.sv
// Multi-cycle adder: adds two N-bit operands K bits per clock, LSB chunk first.
// Ports: i_clk, i_rst_n (sync, active-low), i_valid/o_ready + i_a, i_b, i_cin in;
//        o_valid/i_ready + o_out, o_carry (unsigned), o_ovf (signed) out.
module add_serial
  import add_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_out,
  output logic         o_carry,
  output logic         o_ovf
);

  localparam int NC = N / K;
  localparam int CW = (NC > 1) ? $clog2(NC) : 1;

  generate
    if (K < 1 || (N % K) != 0) begin : g_bad_k
      $error("add_serial: N must be a multiple of K");
    end
  endgenerate

  state_t r_state;
  state_t w_next;

  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_sum;
  logic          r_c;
  logic          r_amsb;
  logic          r_bmsb;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_out;
  logic          r_carry;
  logic          r_ovf;

  logic [K-1:0]  w_csum;
  logic          w_cout;
  logic [N-1:0]  w_sum_nx;
  logic          w_last;

  add_chunk #(.K(K)) u_chunk (
    .i_a    (r_a[K-1:0]),
    .i_b    (r_b[K-1:0]),
    .i_cin  (r_c),
    .o_sum  (w_csum),
    .o_cout (w_cout)
  );

  // New chunk enters at the MSB end; after NC chunks the
  // first one has travelled down to bit 0.
  generate
    if (K == N) begin : g_one
      assign w_sum_nx = w_csum;
    end else begin : g_shift
      assign w_sum_nx = {w_csum, r_sum[N-1:K]};
    end
  endgenerate

  assign w_last  = (r_cnt == CW'(NC - 1));
  assign o_ready = (r_state == IDLE);
  assign o_valid = (r_state == DONE);
  assign o_out   = r_out;
  assign o_carry = r_carry;
  assign o_ovf   = r_ovf;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (i_valid) w_next = RUN;
      RUN:  if (w_last)  w_next = DONE;
      DONE: if (i_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_c     <= 1'b0;
      r_amsb  <= 1'b0;
      r_bmsb  <= 1'b0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (r_state == IDLE && i_valid) begin
        r_a    <= i_a;
        r_b    <= i_b;
        r_c    <= i_cin;
        r_amsb <= i_a[N-1];
        r_bmsb <= i_b[N-1];
        r_cnt  <= '0;
      end else if (r_state == RUN) begin
        r_a   <= r_a >> K;
        r_b   <= r_b >> K;
        r_sum <= w_sum_nx;
        r_c   <= w_cout;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_out   <= w_sum_nx;
          r_carry <= w_cout;
          r_ovf   <= (r_amsb == r_bmsb) &&
                     (w_sum_nx[N-1] != r_amsb);
        end
      end
    end
  end

endmodule

// File: tb/tb_add_serial.sv
// Self-checking bench for add_serial (N=8 with K=2 and K=8).
// Directed cases plus random operands against an arithmetic model.
module tb_add_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ia, ib;
  logic       icin;
  logic       v0, v8, rd0, rd8;
  logic       ordy0, ordy8, ov0, ov8;
  logic [7:0] out0, out8;
  logic       c0, c8, f0, f8;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  add_serial #(.N(8), .K(2)) u_k2 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(v0), .o_ready(ordy0),
    .i_a(ia), .i_b(ib), .i_cin(icin),
    .o_valid(ov0), .i_ready(rd0),
    .o_out(out0), .o_carry(c0), .o_ovf(f0)
  );

  add_serial #(.N(8), .K(8)) u_k8 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(v8), .o_ready(ordy8),
    .i_a(ia), .i_b(ib), .i_cin(icin),
    .o_valid(ov8), .i_ready(rd8),
    .o_out(out8), .o_carry(c8), .o_ovf(f8)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input bit s);
    return s ? ordy8 : ordy0;
  endfunction

  function automatic logic vld(input bit s);
    return s ? ov8 : ov0;
  endfunction

  function automatic logic [9:0] res(input bit s);
    return s ? {f8, c8, out8} : {f0, c0, out0};
  endfunction

  task automatic set_v(input bit s, input logic x);
    if (s) v8 = x; else v0 = x;
  endtask

  task automatic set_r(input bit s, input logic x);
    if (s) rd8 = x; else rd0 = x;
  endtask

  task automatic do_op(input bit s,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input logic cin,
                       input int hold,
                       input bit pulse);
    logic [8:0] full;
    int         sa;
    logic       ovf;
    logic [9:0] exp;
    int         lat;
    full = 9'(a) + 9'(b) + 9'(cin);
    sa   = $signed(a) + $signed(b) + int'(cin);
    ovf  = (sa > 127) || (sa < -128);
    exp  = {ovf, full[8], full[7:0]};
    lat = 0;
    while (!rdy(s) && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("ready_idle", 32'(rdy(s)), 1);
    ia = a; ib = b; icin = cin;
    set_v(s, 1'b1);
    @(posedge clk); #1;
    set_v(s, pulse);
    if (pulse) begin
      ia = ~a; ib = a ^ b; icin = ~cin;
    end
    lat = 0;
    while (!vld(s) && lat < 20) begin
      chk("ready_run", 32'(rdy(s)), 0);
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, s ? 1 : 4);
    chk("result", 32'(res(s)), 32'(exp));
    chk("ready_done", 32'(rdy(s)), 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(vld(s)), 1);
      chk("hold_result", 32'(res(s)), 32'(exp));
    end
    set_r(s, 1'b1);
    @(posedge clk); #1;
    set_r(s, 1'b0);
    set_v(s, 1'b0);
    chk("handoff_valid", 32'(vld(s)), 0);
    chk("handoff_idle", 32'(rdy(s)), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    v0 = 0; v8 = 0; rd0 = 0; rd8 = 0;
    ia = '0; ib = '0; icin = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ov0), 0);
    chk("rst_ready", 32'(ordy0), 1);
    chk("rst_res", 32'(res(0)), 0);
    chk("rst_res8", 32'(res(1)), 0);
    rst_n = 1'b1;

    do_op(0, 8'h7F, 8'h01, 1'b0, 0, 0);
    do_op(0, 8'hFF, 8'h01, 1'b0, 0, 0);
    do_op(0, 8'h80, 8'h80, 1'b0, 0, 0);
    do_op(0, 8'h12, 8'h34, 1'b1, 0, 0);
    do_op(0, 8'h5A, 8'h3C, 1'b0, 3, 1);

    ia = 8'h40; ib = 8'h41; icin = 1'b1;
    v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", 32'(ov0), 0);
    chk("midrst_ready", 32'(ordy0), 1);
    chk("midrst_res", 32'(res(0)), 0);
    rst_n = 1'b1;
    do_op(0, 8'h05, 8'h03, 1'b0, 0, 0);

    do_op(1, 8'hFF, 8'hFF, 1'b1, 0, 0);
    do_op(1, 8'h80, 8'hFF, 1'b0, 2, 1);

    for (int i = 0; i < 1000; i++) begin
      do_op(1'(i & 1),
            8'($urandom), 8'($urandom),
            1'($urandom),
            int'($urandom_range(0, 2)),
            1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
